control_unit: RTL and testbench

Hardwired control unit for the Mini SRC datapath; it replaces the bench-driven strobe sequences with RTL. It observes the instruction register and generates every `datapath` control strobe, one control step (T-state) per clock. Fetch is T0–T2 and execute is T3 onward. Scope covers `ld`, `ldi`, `st`, `addi`, `nop` and `halt`; other opcodes retire as `nop` and flag `IllegalOp`.

---
 rtl/control_pkg.sv | 55 +++++
 rtl/control_decode.sv | 103 ++++++++++
 rtl/control_unit.sv | 146 ++++++++++++++
 tb/tb_control_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit: opcodes,
// control-step enumeration and the bundle of datapath strobes.
package control_pkg;

  // Opcodes recognised by the control unit (IR[31:27])
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Control steps: Rst after reset, T0-T2 fetch, T3-T7 execute, Halted parked
  typedef enum logic [3:0] {
    Rst    = 4'd0,
    T0     = 4'd1,
    T1     = 4'd2,
    T2     = 4'd3,
    T3     = 4'd4,
    T4     = 4'd5,
    T5     = 4'd6,
    T6     = 4'd7,
    T7     = 4'd8,
    Halted = 4'd9
  } state_t;

  // Every strobe the unit drives, plus the status outputs
  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlo_out;
    logic c_out;
    logic ba_out;
    logic gra;
    logic grb;
    logic r_in;
    logic r_out;
    logic read;
    logic write;
    logic alu_add;
    logic run;
    logic illegal_op;
  } ctrl_t;

  // All strobes low, used for reset and as the decode default
  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/control_decode.sv
// Combinational map from (next control step, opcode) to the strobe bundle.
// The top level registers the result, so this describes what the datapath
// will see during the step being entered.
module control_decode
  import control_pkg::*;
#(
  parameter int OPW = 5
) (
  input  state_t         next_state,
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl
);

  logic is_ld;
  logic is_ldi;
  logic is_st;
  logic is_addi;
  logic is_nop;
  logic is_halt;
  logic is_known;
  logic uses_ea;

  assign is_ld    = (opcode == OPW'(OP_LD));
  assign is_ldi   = (opcode == OPW'(OP_LDI));
  assign is_st    = (opcode == OPW'(OP_ST));
  assign is_addi  = (opcode == OPW'(OP_ADDI));
  assign is_nop   = (opcode == OPW'(OP_NOP));
  assign is_halt  = (opcode == OPW'(OP_HALT));
  assign is_known = is_ld | is_ldi | is_st | is_addi | is_nop | is_halt;
  assign uses_ea  = is_ld | is_ldi | is_st;

  // Strobe pattern for the step being entered; everything defaults low
  always_comb begin
    ctrl     = CTRL_IDLE;
    ctrl.run = (next_state != Halted) && (next_state != Rst);
    case (next_state)
      T0: begin
        ctrl.pc_out  = 1'b1;
        ctrl.mar_in  = 1'b1;
        ctrl.inc_pc  = 1'b1;
        ctrl.z_in    = 1'b1;
        ctrl.alu_add = 1'b1;
      end
      T1: begin
        ctrl.read   = 1'b1;
        ctrl.mdr_in = 1'b1;
        ctrl.pc_in  = 1'b1;
      end
      T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      T3: begin
        if (uses_ea) begin
          ctrl.grb    = 1'b1;
          ctrl.ba_out = 1'b1;
          ctrl.y_in   = 1'b1;
        end else if (is_addi) begin
          ctrl.grb   = 1'b1;
          ctrl.r_out = 1'b1;
          ctrl.y_in  = 1'b1;
        end else if (!is_known) begin
          ctrl.illegal_op = 1'b1;
        end
      end
      T4: begin
        ctrl.c_out   = 1'b1;
        ctrl.z_in    = 1'b1;
        ctrl.alu_add = 1'b1;
      end
      T5: begin
        ctrl.zlo_out = 1'b1;
        if (is_ld || is_st) begin
          ctrl.mar_in = 1'b1;
        end else begin
          ctrl.gra  = 1'b1;
          ctrl.r_in = 1'b1;
        end
      end
      T6: begin
        ctrl.mdr_in = 1'b1;
        if (is_st) begin
          ctrl.gra   = 1'b1;
          ctrl.r_out = 1'b1;
        end else begin
          ctrl.read = 1'b1;
        end
      end
      T7: begin
        if (is_st) begin
          ctrl.write = 1'b1;
        end else begin
          ctrl.mdr_out = 1'b1;
          ctrl.gra     = 1'b1;
          ctrl.r_in    = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit for the Mini SRC datapath. Holds the control-step
// register, the opcode latch and the registered strobe outputs; the strobe
// pattern itself comes from control_decode.
module control_unit
  import control_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IRregister,
  input  logic        Stop,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLOout,
  output logic        Cout,
  output logic        BAout,
  output logic        Gra,
  output logic        Grb,
  output logic        Rin,
  output logic        Rout,
  output logic        Read,
  output logic        write,
  output logic        AluAdd,
  output logic        Run,
  output logic        IllegalOp
);

  state_t         state;
  state_t         next_state;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] ir_op;
  logic [OPW-1:0] decode_op;
  ctrl_t          ctrl_next;
  ctrl_t          ctrl_q;
  logic           op_ld;
  logic           op_ldi;
  logic           op_st;
  logic           op_addi;
  logic           op_halt;
  logic           unused_ir_bits;

  assign ir_op          = IRregister[31 -: OPW];
  assign unused_ir_bits = ^IRregister[31-OPW:0];

  assign op_ld   = (op_q == OPW'(OP_LD));
  assign op_ldi  = (op_q == OPW'(OP_LDI));
  assign op_st   = (op_q == OPW'(OP_ST));
  assign op_addi = (op_q == OPW'(OP_ADDI));
  assign op_halt = (op_q == OPW'(OP_HALT));

  // The T3 strobes are registered on the edge that enters T3, so they are
  // decoded from the live IR; every later step uses the latched opcode.
  assign decode_op = (state == T2) ? ir_op : op_q;

  // Next control step; Stop only matters on the way out of T2
  always_comb begin
    next_state = state;
    case (state)
      Rst:    next_state = T0;
      T0:     next_state = T1;
      T1:     next_state = T2;
      T2:     next_state = Stop ? Halted : T3;
      T3: begin
        if (op_halt) begin
          next_state = Halted;
        end else if (op_ld || op_ldi || op_st || op_addi) begin
          next_state = T4;
        end else begin
          next_state = T0;
        end
      end
      T4:     next_state = T5;
      T5:     next_state = (op_ld || op_st) ? T6 : T0;
      T6:     next_state = T7;
      T7:     next_state = T0;
      Halted: next_state = Halted;
      default: next_state = Rst;
    endcase
  end

  control_decode #(
    .OPW(OPW)
  ) u_decode (
    .next_state(next_state),
    .opcode    (decode_op),
    .ctrl      (ctrl_next)
  );

  // Control-step register; reset forces Rst from any step
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= Rst;
    end else begin
      state <= next_state;
    end
  end

  // Opcode latch, captured on the edge that starts T3
  always_ff @(posedge Clock) begin
    if (Reset) begin
      op_q <= '0;
    end else if (state == T2) begin
      op_q <= ir_op;
    end
  end

  // Output register so every strobe is a clean full-cycle level
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ctrl_q <= CTRL_IDLE;
    end else begin
      ctrl_q <= ctrl_next;
    end
  end

  assign PCout     = ctrl_q.pc_out;
  assign PCin      = ctrl_q.pc_in;
  assign IncPC     = ctrl_q.inc_pc;
  assign MARin     = ctrl_q.mar_in;
  assign MDRin     = ctrl_q.mdr_in;
  assign MDRout    = ctrl_q.mdr_out;
  assign IRin      = ctrl_q.ir_in;
  assign Yin       = ctrl_q.y_in;
  assign Zin       = ctrl_q.z_in;
  assign ZLOout    = ctrl_q.zlo_out;
  assign Cout      = ctrl_q.c_out;
  assign BAout     = ctrl_q.ba_out;
  assign Gra       = ctrl_q.gra;
  assign Grb       = ctrl_q.grb;
  assign Rin       = ctrl_q.r_in;
  assign Rout      = ctrl_q.r_out;
  assign Read      = ctrl_q.read;
  assign write     = ctrl_q.write;
  assign AluAdd    = ctrl_q.alu_add;
  assign Run       = ctrl_q.run;
  assign IllegalOp = ctrl_q.illegal_op;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction strobe schedules are
// built from opcode tables and compared against the DUT every cycle.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Stop = 1'b0;
  logic [31:0] IRregister = 32'h0;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, ZLOout;
  logic Cout, BAout, Gra, Grb, Rin, Rout, Read, write, AluAdd, Run, IllegalOp;

  int checks = 0;
  int errors = 0;

  localparam logic [20:0] PCOUT   = 21'd1 << 0;
  localparam logic [20:0] PCIN    = 21'd1 << 1;
  localparam logic [20:0] INCPC   = 21'd1 << 2;
  localparam logic [20:0] MARIN   = 21'd1 << 3;
  localparam logic [20:0] MDRIN   = 21'd1 << 4;
  localparam logic [20:0] MDROUT  = 21'd1 << 5;
  localparam logic [20:0] IRIN    = 21'd1 << 6;
  localparam logic [20:0] YIN     = 21'd1 << 7;
  localparam logic [20:0] ZIN     = 21'd1 << 8;
  localparam logic [20:0] ZLOOUT  = 21'd1 << 9;
  localparam logic [20:0] COUT    = 21'd1 << 10;
  localparam logic [20:0] BAOUT   = 21'd1 << 11;
  localparam logic [20:0] GRA     = 21'd1 << 12;
  localparam logic [20:0] GRB     = 21'd1 << 13;
  localparam logic [20:0] RIN     = 21'd1 << 14;
  localparam logic [20:0] ROUT    = 21'd1 << 15;
  localparam logic [20:0] READ    = 21'd1 << 16;
  localparam logic [20:0] WRITE   = 21'd1 << 17;
  localparam logic [20:0] ALUADD  = 21'd1 << 18;
  localparam logic [20:0] RUN     = 21'd1 << 19;
  localparam logic [20:0] ILLEGAL = 21'd1 << 20;

  logic [20:0] dut_vec;
  assign dut_vec = {IllegalOp, Run, AluAdd, write, Read, Rout, Rin, Grb, Gra,
                    BAout, Cout, ZLOout, Zin, Yin, IRin, MDRout, MDRin, MARin,
                    IncPC, PCin, PCout};

  logic [20:0] exp_v[$];
  string       exp_tag[$];
  logic [20:0] model_seq[$];
  bit          model_parks;

  control_unit #(.OPW(5)) dut (
    .Clock(Clock), .Reset(Reset), .IRregister(IRregister), .Stop(Stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .ZLOout(ZLOout),
    .Cout(Cout), .BAout(BAout), .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout),
    .Read(Read), .write(write), .AluAdd(AluAdd), .Run(Run),
    .IllegalOp(IllegalOp)
  );

  always #5 Clock = ~Clock;

  // Single comparison point used by the cycle checker and the model pins
  task automatic checkOutput(input string name, input logic [20:0] act,
                             input logic [20:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%b want=%b", name, act, want);
    end
  endtask

  // Drive all DUT inputs at once
  task automatic applyStimulus(input logic [31:0] ir, input logic stop_in,
                               input logic rst);
    IRregister = ir;
    Stop       = stop_in;
    Reset      = rst;
  endtask

  // Queue the expected output vector for the cycle that has just begun
  task automatic expectCycle(input logic [20:0] v, input string tag);
    exp_v.push_back(v);
    exp_tag.push_back(tag);
  endtask

  // Reference schedule: fetch steps, then the opcode's execute steps
  task automatic buildModel(input logic [4:0] op, input bit stop_t2);
    logic [20:0] ea;
    logic [20:0] add;
    ea  = RUN | GRB | BAOUT | YIN;
    add = RUN | COUT | ZIN | ALUADD;
    model_seq.delete();
    model_seq.push_back(RUN | PCOUT | MARIN | INCPC | ZIN | ALUADD);
    model_seq.push_back(RUN | READ | MDRIN | PCIN);
    model_seq.push_back(RUN | MDROUT | IRIN);
    model_parks = stop_t2;
    if (stop_t2) return;
    case (op)
      5'b00000: begin
        model_seq.push_back(ea);
        model_seq.push_back(add);
        model_seq.push_back(RUN | ZLOOUT | MARIN);
        model_seq.push_back(RUN | READ | MDRIN);
        model_seq.push_back(RUN | MDROUT | GRA | RIN);
      end
      5'b00001: begin
        model_seq.push_back(ea);
        model_seq.push_back(add);
        model_seq.push_back(RUN | ZLOOUT | GRA | RIN);
      end
      5'b00010: begin
        model_seq.push_back(ea);
        model_seq.push_back(add);
        model_seq.push_back(RUN | ZLOOUT | MARIN);
        model_seq.push_back(RUN | GRA | ROUT | MDRIN);
        model_seq.push_back(RUN | WRITE);
      end
      5'b01100: begin
        model_seq.push_back(RUN | GRB | ROUT | YIN);
        model_seq.push_back(add);
        model_seq.push_back(RUN | ZLOOUT | GRA | RIN);
      end
      5'b11010: model_seq.push_back(RUN);
      5'b11011: begin
        model_seq.push_back(RUN);
        model_parks = 1'b1;
      end
      default: model_seq.push_back(RUN | ILLEGAL);
    endcase
  endtask

  // Reset pulse: outputs all zero in Rst, T0 follows one cycle later
  task automatic doReset();
    applyStimulus($urandom, 1'b0, 1'b1);
    @(posedge Clock); #1;
    expectCycle(21'd0, "reset");
    applyStimulus($urandom, 1'b0, 1'b0);
    @(posedge Clock); #1;
  endtask

  // Run one instruction starting at T0; optional reset at step abort_at
  task automatic runInstr(input logic [31:0] instr, input bit stop_t2,
                          input int abort_at, input string name);
    buildModel(instr[31:27], stop_t2);
    for (int k = 0; k < model_seq.size(); k++) begin
      expectCycle(model_seq[k], $sformatf("%s_T%0d", name, k));
      if (k == abort_at) begin
        applyStimulus($urandom, 1'b0, 1'b1);
        @(posedge Clock); #1;
        expectCycle(21'd0, $sformatf("%s_abort", name));
        applyStimulus($urandom, 1'b0, 1'b0);
        @(posedge Clock); #1;
        return;
      end
      applyStimulus((k <= 2) ? instr : $urandom,
                    (k == 2) ? stop_t2 : 1'($urandom), 1'b0);
      @(posedge Clock); #1;
    end
    if (model_parks) begin
      for (int h = 0; h < 4; h++) begin
        expectCycle(21'd0, $sformatf("%s_halted", name));
        applyStimulus($urandom, 1'($urandom), 1'b0);
        @(posedge Clock); #1;
      end
      doReset();
    end
  endtask

  // Cycle checker: compares DUT outputs with the model on every falling edge
  always @(negedge Clock) begin
    if (exp_v.size() > 0) begin
      checkOutput(exp_tag.pop_front(), dut_vec, exp_v.pop_front());
    end
  end

  // Model pins, directed instructions, then a randomized instruction stream
  initial begin
    buildModel(5'b00000, 1'b0);
    checkOutput("len_ld", 21'(model_seq.size()), 21'd8);
    checkOutput("ld_T7", model_seq[7], 21'h085020);
    buildModel(5'b00010, 1'b0);
    checkOutput("len_st", 21'(model_seq.size()), 21'd8);
    checkOutput("st_T7", model_seq[7], 21'h0A0000);
    buildModel(5'b00001, 1'b0);
    checkOutput("len_ldi", 21'(model_seq.size()), 21'd6);
    buildModel(5'b01100, 1'b0);
    checkOutput("len_addi", 21'(model_seq.size()), 21'd6);
    buildModel(5'b11010, 1'b0);
    checkOutput("len_nop", 21'(model_seq.size()), 21'd4);

    doReset();
    runInstr(32'h00800075, 1'b0, -1, "ld_abs");
    runInstr(32'h00080045, 1'b0, -1, "ld_idx");
    runInstr(32'h09000005, 1'b0, -1, "ldi");
    runInstr(32'h622FFFFF, 1'b0, -1, "addi");
    runInstr(32'h11800090, 1'b0, -1, "st");
    runInstr(32'hD0000000, 1'b0, -1, "nop");
    runInstr(32'hF8000000, 1'b0, -1, "illegal");
    runInstr(32'h11800090, 1'b0, 6, "st_abort");
    runInstr(32'h00800075, 1'b0, -1, "ld_after_abort");
    runInstr(32'hD8000000, 1'b0, -1, "halt");
    runInstr(32'h00800075, 1'b1, -1, "stop_ld");
    runInstr(32'hD8000000, 1'b1, -1, "stop_halt");

    for (int n = 0; n < 80; n++) begin
      logic [4:0]  op;
      logic [31:0] word;
      bit          stp;
      int          ab;
      case ($urandom_range(0, 9))
        0: op = 5'b00000;
        1: op = 5'b00001;
        2: op = 5'b00010;
        3: op = 5'b01100;
        4: op = 5'b11010;
        5: op = 5'b11011;
        default: op = 5'($urandom);
      endcase
      word = {op, 27'($urandom)};
      stp  = ($urandom_range(0, 11) == 0);
      ab   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
      runInstr(word, stp, ab, $sformatf("rnd%0d", n));
    end

    @(negedge Clock);
    #1;
    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
